// File: rtl/hazard_interlock.sv
// hazard_interlock: scoreboard interlock beside DLX decode; raises RAW/WAW/FPU-structural
// stalls and flushes on taken branches resolved in EX.
module hazard_interlock #(
  parameter int LOAD_LAT = 1,
  parameter int FPU_LAT  = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic       id_rs1_fp,
  input  logic       id_rs1_used,
  input  logic [4:0] id_rs2,
  input  logic       id_rs2_fp,
  input  logic       id_rs2_used,
  input  logic [4:0] id_rd,
  input  logic       id_rd_fp,
  input  logic       id_reg_we,
  input  logic       id_is_load,
  input  logic       id_is_fpu,
  input  logic       ex_branch_taken,
  output logic       stall,
  output logic       flush_ifid,
  output logic       flush_idex,
  output logic       fpu_busy
);
  logic [CNT_W-1:0] sb_q [64];
  logic [CNT_W-1:0] sb_d [64];
  logic [CNT_W-1:0] fpu_cnt_q, fpu_cnt_d, lat;
  logic [5:0] rs1_idx, rs2_idx, rd_idx;
  logic rs1_hit, rs2_hit, rd_sb, raw, waw, struct_hz, issue;
  assign rs1_idx = {id_rs1_fp, id_rs1};
  assign rs2_idx = {id_rs2_fp, id_rs2};
  assign rd_idx  = {id_rd_fp, id_rd};
  assign lat = id_is_fpu ? CNT_W'(FPU_LAT) : id_is_load ? CNT_W'(LOAD_LAT) : '0;
  // GPR R0 is hardwired zero: never a hazard source, never tracked as a destination
  assign rs1_hit = id_rs1_used & (id_rs1_fp | (id_rs1 != 5'd0)) & (sb_q[rs1_idx] != '0);
  assign rs2_hit = id_rs2_used & (id_rs2_fp | (id_rs2 != 5'd0)) & (sb_q[rs2_idx] != '0);
  assign rd_sb = id_rd_fp | (id_rd != 5'd0);
  assign raw = rs1_hit | rs2_hit;
  assign waw = id_reg_we & rd_sb & (sb_q[rd_idx] > lat);
  assign struct_hz = id_is_fpu & (fpu_cnt_q != '0);
  assign stall = id_valid & ~ex_branch_taken & (raw | waw | struct_hz);
  assign flush_ifid = ex_branch_taken;
  assign flush_idex = ex_branch_taken | stall;
  assign issue = id_valid & ~stall & ~ex_branch_taken;
  assign fpu_busy = fpu_cnt_q != '0;
  always_comb begin
    for (int i = 0; i < 64; i++) sb_d[i] = (sb_q[i] != '0) ? sb_q[i] - CNT_W'(1) : sb_q[i];
    if (issue & id_reg_we & rd_sb) sb_d[rd_idx] = lat;
    fpu_cnt_d = (issue & id_is_fpu) ? CNT_W'(FPU_LAT - 1) :
                (fpu_cnt_q != '0) ? fpu_cnt_q - CNT_W'(1) : fpu_cnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) sb_q[i] <= '0;
      fpu_cnt_q <= '0;
    end else begin
      sb_q <= sb_d;
      fpu_cnt_q <= fpu_cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_interlock.sv
// tb_hazard_interlock: directed cycle-by-cycle vectors with hand-computed stall/flush expectations.
module tb_hazard_interlock;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic id_valid, id_rs1_fp, id_rs1_used, id_rs2_fp, id_rs2_used, id_rd_fp;
  logic id_reg_we, id_is_load, id_is_fpu, ex_branch_taken;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic stall, flush_ifid, flush_idex, fpu_busy;
  int n_chk = 0;
  int n_pass = 0;

  hazard_interlock dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_fp(id_rs1_fp), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_fp(id_rs2_fp), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_fp(id_rd_fp), .id_reg_we(id_reg_we),
    .id_is_load(id_is_load), .id_is_fpu(id_is_fpu), .ex_branch_taken(ex_branch_taken),
    .stall(stall), .flush_ifid(flush_ifid), .flush_idex(flush_idex), .fpu_busy(fpu_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic drv(input logic v, input logic [4:0] rd, input logic fd,
                     input logic [4:0] r1, input logic f1, input logic [4:0] r2, input logic f2,
                     input logic ld, input logic fp, input logic br);
    id_valid = v; id_rd = rd; id_rd_fp = fd; id_reg_we = v;
    id_rs1 = r1; id_rs1_fp = f1; id_rs1_used = v;
    id_rs2 = r2; id_rs2_fp = f2; id_rs2_used = v;
    id_is_load = ld; id_is_fpu = fp; ex_branch_taken = br;
  endtask

  task automatic cyc_op(input logic [4:0] rd, input logic fd, input logic [4:0] r1, input logic f1,
                        input logic [4:0] r2, input logic f2, input logic ld, input logic fp,
                        input logic br);
    @(negedge clk);
    drv(1'b1, rd, fd, r1, f1, r2, f2, ld, fp, br);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_flush_ifid", flush_ifid, 1'b0);
    chk("rst_flush_idex", flush_idex, 1'b0);
    chk("rst_fpu_busy", fpu_busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    // load R3 <- [R1], then ADD R4,R3,R5
    cyc_op(5'd3, 0, 5'd1, 0, 5'd0, 0, 1, 0, 0);
    chk("ld_issue", stall, 1'b0);
    cyc_op(5'd4, 0, 5'd3, 0, 5'd5, 0, 0, 0, 0);
    chk("ldu_stall", stall, 1'b1);
    chk("ldu_flush_idex", flush_idex, 1'b1);
    chk("ldu_flush_ifid", flush_ifid, 1'b0);
    cyc_op(5'd4, 0, 5'd3, 0, 5'd5, 0, 0, 0, 0);
    chk("ldu_issue", stall, 1'b0);
    chk("ldu_idex_clr", flush_idex, 1'b0);
    idle(1);
    // MULTF F2 then dependent ADDF F4,F2,F6
    cyc_op(5'd2, 1, 5'd10, 1, 5'd12, 1, 0, 1, 0);
    chk("mult_issue", stall, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc_op(5'd4, 1, 5'd2, 1, 5'd6, 1, 0, 1, 0);
      chk($sformatf("fpraw_stall%0d", i), stall, 1'b1);
    end
    chk("fpraw_busy_t4", fpu_busy, 1'b0);
    cyc_op(5'd4, 1, 5'd2, 1, 5'd6, 1, 0, 1, 0);
    chk("fpraw_issue", stall, 1'b0);
    idle(1);
    #1;
    chk("fpraw_busy", fpu_busy, 1'b1);
    idle(4);
    #1;
    chk("fpu_idle", fpu_busy, 1'b0);
    // R0 destination is untracked; F0 is ordinary
    cyc_op(5'd0, 0, 5'd1, 0, 5'd0, 0, 1, 0, 0);
    cyc_op(5'd6, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    chk("r0_nostall", stall, 1'b0);
    cyc_op(5'd0, 1, 5'd1, 0, 5'd0, 0, 1, 0, 0);
    cyc_op(5'd7, 0, 5'd0, 1, 5'd0, 0, 0, 0, 0);
    chk("f0_stall", stall, 1'b1);
    cyc_op(5'd7, 0, 5'd0, 1, 5'd0, 0, 0, 0, 0);
    chk("f0_issue", stall, 1'b0);
    idle(1);
    // WAW: FPU writes F8, load to F8 must wait until sb[F8] <= 1
    cyc_op(5'd8, 1, 5'd10, 1, 5'd12, 1, 0, 1, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc_op(5'd8, 1, 5'd1, 0, 5'd0, 0, 1, 0, 0);
      chk($sformatf("waw_stall%0d", i), stall, 1'b1);
    end
    cyc_op(5'd8, 1, 5'd1, 0, 5'd0, 0, 1, 0, 0);
    chk("waw_issue", stall, 1'b0);
    idle(5);
    // two independent FPU ops: structural hazard
    cyc_op(5'd10, 1, 5'd12, 1, 5'd14, 1, 0, 1, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc_op(5'd16, 1, 5'd18, 1, 5'd20, 1, 0, 1, 0);
      chk($sformatf("st_stall%0d", i), stall, 1'b1);
      chk($sformatf("st_busy%0d", i), fpu_busy, 1'b1);
    end
    cyc_op(5'd16, 1, 5'd18, 1, 5'd20, 1, 0, 1, 0);
    chk("st_issue", stall, 1'b0);
    chk("st_busy_clr", fpu_busy, 1'b0);
    idle(6);
    // load-use meets taken branch: squash, no scoreboard write of R9
    cyc_op(5'd3, 0, 5'd1, 0, 5'd0, 0, 1, 0, 0);
    cyc_op(5'd9, 0, 5'd3, 0, 5'd0, 0, 1, 0, 1);
    chk("br_stall", stall, 1'b0);
    chk("br_flush_ifid", flush_ifid, 1'b1);
    chk("br_flush_idex", flush_idex, 1'b1);
    cyc_op(5'd11, 0, 5'd9, 0, 5'd0, 0, 0, 0, 0);
    chk("br_no_sb", stall, 1'b0);
    idle(1);
    #1;
    ex_branch_taken = 1'b1;
    #1;
    chk("br_idle_idex", flush_idex, 1'b1);
    idle(1);
    // asynchronous reset wipes pending FPU result and occupancy
    cyc_op(5'd2, 1, 5'd10, 1, 5'd12, 1, 0, 1, 0);
    idle(1);
    #1;
    chk("pre_rst_busy", fpu_busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_rst_busy", fpu_busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    cyc_op(5'd4, 1, 5'd2, 1, 5'd6, 1, 0, 1, 0);
    chk("post_rst_issue", stall, 1'b0);
    idle(1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hazard_interlock.md
Name: hazard_interlock

Overview:
Scoreboard-based interlock unit for the pipelined DLX core. It sits beside the decode stage and consumes the decoded fields of the instruction in ID: source/destination registers, register-file selects, RegWE, load and FPU class. It tracks pending writes to the 32 GPRs and 32 FPRs and the occupancy of the non-pipelined FPU. It stalls IF/ID, injects bubbles into ID/EX, and flushes on taken branches/jumps resolved in EX.

Parameters:
LOAD_LAT, 1, cycles a load result trails the forwarding point (load-use bubbles); 0..7
FPU_LAT, 4, cycles an FPU result trails the forwarding point; 1..7
CNT_W, 3, width of each scoreboard down-counter; must hold max(LOAD_LAT, FPU_LAT)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
id_valid  in  1  ID holds a real (non-bubble) instruction
id_rs1  in  5  source 1 register index
id_rs1_fp  in  1  source 1 read from FPR file (else GPR)
id_rs1_used  in  1  source 1 actually read
id_rs2  in  5  source 2 register index
id_rs2_fp  in  1  source 2 read from FPR file
id_rs2_used  in  1  source 2 actually read
id_rd  in  5  destination register index (after RegDest mux)
id_rd_fp  in  1  destination is FPR (FPDest)
id_reg_we  in  1  instruction writes a register
id_is_load  in  1  memory load
id_is_fpu  in  1  FPU-executed instruction
ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle
stall  out  1  hold PC and IF/ID this cycle
flush_ifid  out  1  squash IF/ID register
flush_idex  out  1  load bubble into ID/EX
fpu_busy  out  1  FPU occupancy counter non-zero

Behaviour:
- State: sb[0..63] (index = {fp, reg}), each CNT_W bits; fpu_cnt, CNT_W bits. Reset: all zero. Outputs are combinational, so all outputs are 0 after reset while id_valid=0 and ex_branch_taken=0.
- lat = id_is_fpu ? FPU_LAT : (id_is_load ? LOAD_LAT : 0). FPU wins if both are set.
- A GPR R0 destination is never scoreboarded. A GPR R0 source never causes a RAW stall. F0 is an ordinary register.
- raw = (id_rs1_used & sb[rs1] != 0) | (id_rs2_used & sb[rs2] != 0).
- waw = id_reg_we & dest scoreboarded & sb[rd] > lat. This keeps writeback in order.
- struct = id_is_fpu & fpu_cnt != 0.
- stall = id_valid & ~ex_branch_taken & (raw | waw | struct).
- flush_ifid = ex_branch_taken.
- flush_idex = ex_branch_taken | stall. Flush has priority over stall.
- issue = id_valid & ~stall & ~ex_branch_taken.
- Each rising edge: every non-zero sb entry and fpu_cnt decrements by 1, saturating at 0.
- Then, if issue & id_reg_we and the dest is scoreboarded: sb[rd] <= lat. This set overrides the decrement for that entry.
- If issue & id_is_fpu: fpu_cnt <= FPU_LAT-1. This allows independent FPU ops to issue FPU_LAT cycles apart.
- Latency contract: a producer issued in cycle t with latency L lets a dependent issue in cycle t+L+1.
  - ALU (L=0): no bubble.
  - Load (L=1): one bubble.
- Simultaneous stall and branch: the stalled ID instruction is squashed. No scoreboard write occurs; decrements still happen.
- rs1 == rs2 == rd is legal. The check uses the pre-update sb.
- Reset mid-operation clears all pending entries immediately. Upstream pipeline registers are reset in the same cycle.

Test Plan:
- Reset, then load to R3, next cycle ADD R4,R3,R5 -> stall=1 and flush_idex=1 for exactly 1 cycle; ADD issues in cycle t+2.
- FPU MULT F2 at t, ADDF F4,F2,F6 at t+1 (FPU_LAT=4) -> stall high for cycles t+1..t+4; issue at t+5.
- Load to R0, then ADD reading R0 -> no stall. Load to F0, then a reader of F0 -> 1 stall.
- FPU op writing F8 at t, load (id_rd_fp=1, F8) at t+1 -> WAW stall until sb[F8] ≤ 1, then issue.
- Two independent FPU ops back-to-back -> fpu_busy=1 and stall for 3 cycles; the second issues at t+4.
- Load-use stall active when ex_branch_taken=1 -> stall=0, flush_ifid=1, flush_idex=1, no sb update. Asserting reset while sb entries are non-zero -> all entries 0 and a subsequent dependent issues with no stall.
